// File: rtl/rls_coef_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rls_coef_sink_pkg
// Description : Shared read-state encoding and default sizing for the
//               RLS coefficient sink.
// Revision    : 1.0 - initial release
// ============================================================================
package rls_coef_sink_pkg;

    localparam int DEF_N  = 16;
    localparam int DEF_W  = 32;
    localparam int DEF_CW = 32;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rls_coef_bank.sv
`default_nettype none
// ============================================================================
// Module      : rls_coef_bank
// Description : N x W coefficient bank, one write port, one registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module rls_coef_bank
    import rls_coef_sink_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int AW = addr_width(DEF_N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [N];
    logic [W-1:0] rdata_q;

    // RAM contents carry no reset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/rls_coef_sink.sv
`default_nettype none
// ============================================================================
// Module      : rls_coef_sink
// Description : Ping-pong block buffer between RLS solver and a ready/valid
//               stream. Define RLS_SINK_CHECKSUM_EN to append a sum word.
// Revision    : 1.0 - initial release
// ============================================================================
module rls_coef_sink
    import rls_coef_sink_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write,
    input  logic [W-1:0]  x_in,
    input  logic          final_in,
    output logic          m_valid,
    output logic [W-1:0]  m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic [CW-1:0] blocks,
    output logic          overflow,
    output logic          done
);

    localparam int AW = addr_width(N);
    localparam int IW = $clog2(N + 1);
`ifdef RLS_SINK_CHECKSUM_EN
    localparam int LAST_IDX = N;
`else
    localparam int LAST_IDX = N - 1;
`endif

    rd_state_e     state_q, state_d;
    logic [1:0]    full_q, full_d;
    logic          fill_ptr_q, fill_ptr_d;
    logic          drain_ptr_q, drain_ptr_d;
    logic [AW-1:0] wcount_q, wcount_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] blocks_q, blocks_d;
    logic          overflow_q, overflow_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic          done_q, done_d;

    logic          drop_now;
    logic          commit;
    logic [1:0]    bank_we;
    logic [1:0]    bank_re;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  bank_rdata [2];

`ifdef RLS_SINK_CHECKSUM_EN
    logic [W-1:0]  csum_q [2];
    logic [W-1:0]  csum_d [2];
`endif

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        wcount_d    = wcount_q;
        drop_d      = drop_q;
        blocks_d    = blocks_q;
        overflow_d  = overflow_q;
        idx_d       = idx_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        drop_now    = 1'b0;
        commit      = 1'b0;
        bank_we     = 2'b00;
        bank_re     = 2'b00;
        rd_addr     = '0;
`ifdef RLS_SINK_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        // The drop decision is latched on the first pulse and held for the whole block.
        if (write) begin
            drop_now = (wcount_q == '0) ? full_q[fill_ptr_q] : drop_q;
            if (wcount_q == AW'(N - 1)) begin
                wcount_d = '0;
                drop_d   = 1'b0;
                commit   = !drop_now;
            end else begin
                wcount_d = wcount_q + AW'(1);
                drop_d   = drop_now;
            end
            if (drop_now) begin
                overflow_d = 1'b1;
            end else begin
                bank_we[fill_ptr_q] = 1'b1;
`ifdef RLS_SINK_CHECKSUM_EN
                csum_d[fill_ptr_q] = (wcount_q == '0) ? x_in : csum_q[fill_ptr_q] + x_in;
`endif
            end
        end

        if (commit) begin
            full_d[fill_ptr_q] = 1'b1;
            fill_ptr_d         = !fill_ptr_q;
            blocks_d           = blocks_q + CW'(1);
        end

        // Word 0 is fetched on the edge a bank becomes visible, so data lines up with m_valid.
        case (state_q)
            RD_IDLE: begin
                if (full_d[drain_ptr_q]) begin
                    state_d              = RD_STREAM;
                    m_valid_d            = 1'b1;
                    m_last_d             = 1'b0;
                    idx_d                = '0;
                    bank_re[drain_ptr_q] = 1'b1;
                end
            end
            RD_STREAM: begin
                if (m_valid_q && m_ready) begin
                    if (m_last_q) begin
                        full_d[drain_ptr_q] = 1'b0;
                        drain_ptr_d         = !drain_ptr_q;
                        idx_d               = '0;
                        m_last_d            = 1'b0;
                        if (full_d[!drain_ptr_q]) begin
                            bank_re[!drain_ptr_q] = 1'b1;
                        end else begin
                            state_d   = RD_IDLE;
                            m_valid_d = 1'b0;
                        end
                    end else begin
                        idx_d    = idx_q + IW'(1);
                        m_last_d = (idx_d == IW'(LAST_IDX));
                        if (idx_d < IW'(N)) begin
                            bank_re[drain_ptr_q] = 1'b1;
                            rd_addr              = AW'(idx_d);
                        end
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        done_d = final_in && (full_d == 2'b00) && (wcount_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RD_IDLE;
            full_q      <= 2'b00;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            wcount_q    <= '0;
            drop_q      <= 1'b0;
            blocks_q    <= '0;
            overflow_q  <= 1'b0;
            idx_q       <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            done_q      <= 1'b0;
`ifdef RLS_SINK_CHECKSUM_EN
            csum_q[0]   <= '0;
            csum_q[1]   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            wcount_q    <= wcount_d;
            drop_q      <= drop_d;
            blocks_q    <= blocks_d;
            overflow_q  <= overflow_d;
            idx_q       <= idx_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            done_q      <= done_d;
`ifdef RLS_SINK_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            rls_coef_bank #(
                .N  (N),
                .W  (W),
                .AW (AW)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[b]),
                .waddr (wcount_q),
                .wdata (x_in),
                .re    (bank_re[b]),
                .raddr (rd_addr),
                .rdata (bank_rdata[b])
            );
        end
    endgenerate

    always_comb begin
        m_data = '0;
        if (m_valid_q) begin
            m_data = bank_rdata[drain_ptr_q];
`ifdef RLS_SINK_CHECKSUM_EN
            if (idx_q == IW'(N)) begin
                m_data = csum_q[drain_ptr_q];
            end
`endif
        end
    end

    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign blocks   = blocks_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rls_coef_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_rls_coef_sink
// Description : Self-checking bench for rls_coef_sink against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rls_coef_sink;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 32;
`ifdef RLS_SINK_CHECKSUM_EN
    localparam int WPB = N + 1;
`else
    localparam int WPB = N;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write = 1'b0;
    logic [W-1:0]  x_in = '0;
    logic          final_in = 1'b0;
    logic          m_ready = 1'b0;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic [CW-1:0] blocks;
    logic          overflow;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: blocks become word lists once all N words have arrived.
    int            mdl_count = 0;
    bit            mdl_drop = 1'b0;
    int            buffered = 0;
    logic [W-1:0]  cur_blk[$];
    logic [W-1:0]  exp_data[$];
    bit            exp_last[$];
    logic [CW-1:0] mdl_blocks = '0;
    bit            mdl_ovf = 1'b0;
    bit            mdl_done = 1'b0;

    rls_coef_sink #(.N(N), .W(W), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .x_in     (x_in),
        .final_in (final_in),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .blocks   (blocks),
        .overflow (overflow),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mdl_count = 0;
        mdl_drop  = 1'b0;
        buffered  = 0;
        cur_blk.delete();
        exp_data.delete();
        exp_last.delete();
        mdl_blocks = '0;
        mdl_ovf    = 1'b0;
        mdl_done   = 1'b0;
    endtask

    task automatic step(input bit wr, input logic [W-1:0] d, input bit rdy);
        int           buf_pre;
        logic [W-1:0] sum;
        write   = wr;
        x_in    = d;
        m_ready = rdy;
        buf_pre = buffered;
        if (rdy && exp_data.size() > 0) begin
            if (exp_last[0]) buffered--;
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
        end
        if (wr) begin
            if (mdl_count == 0) mdl_drop = (buf_pre == 2);
            if (mdl_drop) mdl_ovf = 1'b1;
            else cur_blk.push_back(d);
            if (mdl_count == N - 1) begin
                if (!mdl_drop) begin
                    sum = '0;
                    foreach (cur_blk[i]) begin
                        exp_data.push_back(cur_blk[i]);
                        exp_last.push_back((WPB == N) && (i == N - 1));
                        sum = sum + cur_blk[i];
                    end
`ifdef RLS_SINK_CHECKSUM_EN
                    exp_data.push_back(sum);
                    exp_last.push_back(1'b1);
`endif
                    buffered++;
                    mdl_blocks = mdl_blocks + 1'b1;
                end
                mdl_count = 0;
                mdl_drop  = 1'b0;
                cur_blk.delete();
            end else begin
                mdl_count++;
            end
        end
        mdl_done = final_in && (buffered == 0) && (mdl_count == 0);
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic test_reset();
        final_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 6;
        if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        if (m_last !== 1'b0) begin n_errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
        if (m_data !== '0) begin n_errors++; $display("FAIL reset_m_data got %h want 0", m_data); end
        if (blocks !== '0) begin n_errors++; $display("FAIL reset_blocks got %0d want 0", blocks); end
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
        final_in = 1'b0;
        reset = 1'b1;
        model_reset();
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_single_block();
        logic [W-1:0] got_d[$];
        bit           got_l[$];
        logic [W-1:0] want;
        for (int i = 0; i < N; i++) begin
            step(1'b1, W'(i + 1), 1'b1);
            n_checks++;
            if (m_valid !== (i == N - 1)) begin
                n_errors++;
                $display("FAIL single_latency write%0d m_valid got %b want %b", i, m_valid, (i == N - 1));
            end
        end
        n_checks += 2;
        if (m_data !== W'(1)) begin n_errors++; $display("FAIL single_first_word got %h want 1", m_data); end
        if (blocks !== CW'(1)) begin n_errors++; $display("FAIL single_blocks got %0d want 1", blocks); end
        for (int c = 0; c < 12 && m_valid === 1'b1; c++) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            step(1'b0, '0, 1'b1);
        end
        n_checks++;
        if (got_d.size() != WPB) begin
            n_errors++;
            $display("FAIL single_count got %0d want %0d", got_d.size(), WPB);
        end else begin
            for (int i = 0; i < WPB; i++) begin
                want = (i < N) ? W'(i + 1) : W'(N * (N + 1) / 2);
                n_checks++;
                if (got_d[i] !== want || got_l[i] !== (i == WPB - 1)) begin
                    n_errors++;
                    $display("FAIL single_word%0d got %h/%b want %h/%b", i, got_d[i], got_l[i], want, (i == WPB - 1));
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [CW-1:0] base;
        logic [W-1:0]  got_d[$];
        bit            got_l[$];
        logic [W-1:0]  want;
        logic [W-1:0]  sum;
        base = blocks;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < N; k++)
                step(1'b1, W'(100 + b * N + k), 1'b0);
        n_checks += 3;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        if (blocks !== base + CW'(2)) begin n_errors++; $display("FAIL ovf_blocks got %0d want %0d", blocks, base + CW'(2)); end
        if (m_valid !== 1'b1 || m_data !== W'(100)) begin
            n_errors++; $display("FAIL ovf_head got %b/%h want 1/%h", m_valid, m_data, W'(100));
        end
        for (int c = 0; c < 40 && m_valid === 1'b1; c++) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            step(1'b0, '0, 1'b1);
        end
        n_checks++;
        if (got_d.size() != 2 * WPB) begin
            n_errors++;
            $display("FAIL ovf_count got %0d want %0d", got_d.size(), 2 * WPB);
        end else begin
            for (int b = 0; b < 2; b++) begin
                sum = '0;
                for (int k = 0; k < WPB; k++) begin
                    want = (k < N) ? W'(100 + b * N + k) : sum;
                    if (k < N) sum = sum + want;
                    n_checks++;
                    if (got_d[b * WPB + k] !== want || got_l[b * WPB + k] !== (k == WPB - 1)) begin
                        n_errors++;
                        $display("FAIL ovf_word b%0d k%0d got %h/%b want %h/%b", b, k,
                                 got_d[b * WPB + k], got_l[b * WPB + k], want, (k == WPB - 1));
                    end
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_stall();
        logic [W-1:0] prev_d;
        bit           prev_stall;
        for (int k = 0; k < N; k++) step(1'b1, W'($urandom), 1'b0);
        for (int c = 0; c < 30; c++) begin
            prev_d     = m_data;
            prev_stall = (m_valid === 1'b1) && c[0];
            step(1'b0, '0, !c[0]);
            n_checks++;
            if (m_valid !== (exp_data.size() > 0)) begin
                n_errors++; $display("FAIL stall_valid c%0d got %b want %b", c, m_valid, (exp_data.size() > 0));
            end else if (exp_data.size() > 0 && (m_data !== exp_data[0] || m_last !== exp_last[0])) begin
                n_errors++; $display("FAIL stall_word c%0d got %h/%b want %h/%b", c, m_data, m_last, exp_data[0], exp_last[0]);
            end
            if (prev_stall) begin
                n_checks++;
                if (m_data !== prev_d) begin
                    n_errors++; $display("FAIL stall_hold c%0d got %h want %h", c, m_data, prev_d);
                end
            end
        end
        n_checks++;
        if (m_valid !== 1'b0) begin n_errors++; $display("FAIL stall_drained got %b want 0", m_valid); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got_d[$];
        step(1'b1, W'(55), 1'b0);
        step(1'b1, W'(56), 1'b0);
        reset = 1'b0;
        #2;
        n_checks += 4;
        if (m_valid !== 1'b0 || m_last !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid got %b/%b want 0/0", m_valid, m_last); end
        if (m_data !== '0) begin n_errors++; $display("FAIL rstmid_data got %h want 0", m_data); end
        if (blocks !== '0) begin n_errors++; $display("FAIL rstmid_blocks got %0d want 0", blocks); end
        if (overflow !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL rstmid_flags got %b/%b want 0/0", overflow, done); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) step(1'b1, W'(7 + k), 1'b0);
        n_checks += 2;
        if (blocks !== CW'(1)) begin n_errors++; $display("FAIL rstmid_newblock got %0d want 1", blocks); end
        if (m_data !== W'(7)) begin n_errors++; $display("FAIL rstmid_head got %h want 7", m_data); end
        for (int c = 0; c < 12 && m_valid === 1'b1; c++) begin
            got_d.push_back(m_data);
            step(1'b0, '0, 1'b1);
        end
        n_checks++;
        if (got_d.size() != WPB || got_d[N - 1] !== W'(7 + N - 1)) begin
            n_errors++; $display("FAIL rstmid_drain got %0d words want %0d", got_d.size(), WPB);
        end
    endtask

    task automatic test_done();
        for (int k = 0; k < N; k++) step(1'b1, W'($urandom), 1'b0);
        final_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, '0, 1'b0);
            n_checks++;
            if (done !== 1'b0) begin n_errors++; $display("FAIL done_early c%0d got %b want 0", c, done); end
        end
        for (int c = 0; c < 12 && m_valid === 1'b1; c++) begin
            step(1'b0, '0, 1'b1);
            n_checks++;
            if (done !== mdl_done) begin n_errors++; $display("FAIL done_track c%0d got %b want %b", c, done, mdl_done); end
        end
        n_checks++;
        if (done !== 1'b1) begin n_errors++; $display("FAIL done_final got %b want 1", done); end
        final_in = 1'b0;
        step(1'b0, '0, 1'b0);
    endtask

`ifdef RLS_SINK_CHECKSUM_EN
    task automatic test_checksum();
        logic [W-1:0] got_d[$];
        bit           got_l[$];
        step(1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, W'(1), 1'b0);
        step(1'b1, W'(2), 1'b0);
        step(1'b1, W'(3), 1'b0);
        for (int c = 0; c < 12 && m_valid === 1'b1; c++) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            step(1'b0, '0, 1'b1);
        end
        n_checks++;
        if (got_d.size() != 5) begin
            n_errors++; $display("FAIL csum_count got %0d want 5", got_d.size());
        end else begin
            n_checks += 2;
            if (got_d[4] !== 32'h0000_0005 || got_l[4] !== 1'b1) begin
                n_errors++; $display("FAIL csum_word got %h/%b want 00000005/1", got_d[4], got_l[4]);
            end
            if (got_l[3] !== 1'b0) begin n_errors++; $display("FAIL csum_last_early got %b want 0", got_l[3]); end
        end
    endtask
`endif

    task automatic test_random();
        bit wr;
        bit rdy;
        for (int c = 0; c < 600; c++) begin
            wr  = ($urandom_range(0, 3) != 0);
            rdy = ((c / 100) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 31) == 0) final_in = !final_in;
            step(wr, W'($urandom), rdy);
            n_checks++;
            if (m_valid !== (exp_data.size() > 0)) begin
                n_errors++; $display("FAIL rand_valid c%0d got %b want %b", c, m_valid, (exp_data.size() > 0));
            end else if (exp_data.size() > 0 && (m_data !== exp_data[0] || m_last !== exp_last[0])) begin
                n_errors++; $display("FAIL rand_word c%0d got %h/%b want %h/%b", c, m_data, m_last, exp_data[0], exp_last[0]);
            end
            n_checks++;
            if (blocks !== mdl_blocks || overflow !== mdl_ovf || done !== mdl_done) begin
                n_errors++;
                $display("FAIL rand_status c%0d got %0d/%b/%b want %0d/%b/%b", c, blocks, overflow, done,
                         mdl_blocks, mdl_ovf, mdl_done);
            end
        end
        final_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_done();
`ifdef RLS_SINK_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
